// File: rtl/vec_store_unit_if.sv
// Bus bundle between a vector-store requester and vec_store_unit.
// Handshake: start is a one-cycle request taken only when the unit is idle (busy=0, done_vst=0); a write beat completes on a clock edge where wr=1 and mem_ready=1, and mem_ready has no meaning while wr=0.
interface vec_store_unit_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
);
  logic                     start;
  logic [DATA_W*LANES-1:0]  vector_reg;
  logic [ADDR_W-1:0]        addr_in;
  logic [ADDR_W-1:0]        stride;
  logic [LANES-1:0]         mask;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        addr;
  logic                     wr;
  logic [DATA_W-1:0]        data_in;
  logic                     busy;
  logic                     done_vst;

  modport master (
    output start, vector_reg, addr_in, stride, mask, mem_ready,
    input  addr, wr, data_in, busy, done_vst
  );

  modport slave (
    input  start, vector_reg, addr_in, stride, mask, mem_ready,
    output addr, wr, data_in, busy, done_vst
  );
endinterface

// File: rtl/vec_store_unit.sv
// Vector-store engine: serialises a captured LANES x DATA_W register into strided memory
// writes, one lane slot per cycle, stalling only on enabled lanes while memory is not ready.
module vec_store_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  vec_store_unit_if.slave bus,
  output logic [1:0]      state_o
);
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  lane_q [LANES];
  logic [LANES-1:0]   mask_q;
  logic [ADDR_W-1:0]  stride_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               wr_q;
  logic               busy_q;
  logic               done_q;

  logic [PTR_W-1:0]   ptr_nxt;
  logic               last_lane;
  logic               advance;

  assign ptr_nxt   = ptr_q + 1'b1;
  assign last_lane = (ptr_q == PTR_W'(LANES - 1));
  // A masked lane always moves on after one cycle so timing does not depend on the mask.
  assign advance   = !mask_q[ptr_q] || bus.mem_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      mask_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          wr_q   <= 1'b0;
          data_q <= '0;
          if (bus.start) begin
            for (int i = 0; i < LANES; i++) lane_q[i] <= bus.vector_reg[i*DATA_W +: DATA_W];
            mask_q   <= bus.mask;
            stride_q <= bus.stride;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            if (bus.mask != '0) begin
              state_q <= S_WRITE;
              addr_q  <= bus.addr_in;
              wr_q    <= bus.mask[0];
              data_q  <= bus.mask[0] ? bus.vector_reg[DATA_W-1:0] : '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (advance) begin
            if (last_lane) begin
              state_q <= S_DONE;
              wr_q    <= 1'b0;
              data_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              // Running-sum address keeps the stride multiply out of the datapath.
              ptr_q  <= ptr_nxt;
              addr_q <= addr_q + stride_q;
              wr_q   <= mask_q[ptr_nxt];
              data_q <= mask_q[ptr_nxt] ? lane_q[ptr_nxt] : '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.addr     = addr_q;
  assign bus.wr       = wr_q;
  assign bus.data_in  = data_q;
  assign bus.busy     = busy_q;
  assign bus.done_vst = done_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_vec_store_unit.sv
// Bench for vec_store_unit: stores are issued with expected writes queued from a
// base + i*stride model; a negedge monitor pops and compares every accepted write.
module tb_vec_store_unit;
  localparam int DW = 16;
  localparam int LN = 16;
  localparam int AW = 16;

  logic clk;
  logic rst_n;
  logic [1:0] state_dbg;

  vec_store_unit_if #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) bus ();

  vec_store_unit #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_exp = 0;
  int start_cyc = 0;
  int stall_cnt = 0;
  int last_done_cyc = 0;
  bit exp_mask0 = 0;
  bit rdy_rand = 0;
  bit prev_stall = 0;
  bit done_prev = 0;
  logic [AW+DW:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.mem_ready = ($urandom_range(0, 9) < 7);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [AW+DW-1:0] exp_w;
    if (rst_n) begin
      if (prev_stall) check("stall_hold", {bus.wr, bus.addr, bus.data_in}, held);
      if (bus.wr) begin
        check("wr_only_when_busy", bus.busy, 1);
        if (bus.mem_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.addr, bus.data_in}, '1);
          end else begin
            exp_w = exp_q.pop_front();
            check("write_addr_data", {bus.addr, bus.data_in}, exp_w);
          end
        end else begin
          stall_cnt++;
        end
      end
      prev_stall = bus.wr && !bus.mem_ready;
      held = {bus.wr, bus.addr, bus.data_in};
      if (done_prev) begin
        check("done_one_cycle", bus.done_vst, 0);
        check("busy_after_done", bus.busy, 0);
      end
      if (bus.done_vst) begin
        if (done_exp == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_exp--;
          check("done_all_written", exp_q.size(), 0);
          check("done_cycle", cyc, exp_mask0 ? start_cyc : start_cyc + LN + stall_cnt);
          check("wr_low_in_done", bus.wr, 0);
          last_done_cyc = cyc;
        end
      end
      done_prev = bus.done_vst;
    end else begin
      prev_stall = 0;
      done_prev = 0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW*LN-1:0] ramp_vec(input logic [DW-1:0] base);
    logic [DW*LN-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = base + DW'(i);
    return v;
  endfunction

  function automatic logic [DW*LN-1:0] rand_vec();
    logic [DW*LN-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done_vst) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done_vst && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("done_timeout", 1, 0);
  endtask

  task automatic scramble_inputs();
    bus.vector_reg = rand_vec();
    bus.addr_in    = AW'($urandom);
    bus.stride     = AW'($urandom);
    bus.mask       = LN'($urandom);
  endtask

  task automatic start_store(input logic [DW*LN-1:0] vec, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input logic [LN-1:0] mask);
    wait_idle();
    bus.start      = 1'b1;
    bus.vector_reg = vec;
    bus.addr_in    = base;
    bus.stride     = stride;
    bus.mask       = mask;
    for (int i = 0; i < LN; i++)
      if (mask[i]) exp_q.push_back({AW'(base + AW'(i) * stride), vec[i*DW +: DW]});
    exp_mask0 = (mask == '0);
    done_exp++;
    @(posedge clk); #1;
    start_cyc = cyc;
    stall_cnt = 0;
    bus.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic pulse_ignored_start();
    bus.start = 1'b1;
    scramble_inputs();
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LN-1:0] m;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.vector_reg = '0;
    bus.addr_in = '0;
    bus.stride = '0;
    bus.mask = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_addr", bus.addr, 0);
    check("rst_wr", bus.wr, 0);
    check("rst_data", bus.data_in, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done_vst, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk); #1;

    // Contiguous full store, memory always ready
    start_store(ramp_vec(16'h1000), 16'h0100, 16'h0001, 16'hFFFF);
    wait_done();
    @(negedge clk); #1;
    check("full_done_latency", last_done_cyc - start_cyc, LN);
    pulse_ignored_start();

    // Negative stride with address wrap
    start_store(rand_vec(), 16'h0003, 16'hFFFE, 16'hFFFF);
    // Sparse mask
    start_store(rand_vec(), 16'h2000, 16'h0004, 16'h00A5);

    // Memory back-pressure on lane 4
    start_store(ramp_vec(16'h4000), 16'h0300, 16'h0001, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    wait_done();
    @(negedge clk); #1;
    check("stall_done_latency", last_done_cyc - start_cyc, LN + 3);
    @(posedge clk); #1;

    // Empty mask, then a start pulsed mid-store
    start_store(rand_vec(), 16'h5000, 16'h0001, 16'h0000);
    start_store(ramp_vec(16'h6000), 16'h0600, 16'h0002, 16'hF0F0);
    repeat (3) @(posedge clk);
    #1;
    pulse_ignored_start();

    // Asynchronous reset during lane 7
    start_store(ramp_vec(16'h7000), 16'h0700, 16'h0001, 16'hFFFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr", bus.wr, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_addr", bus.addr, 0);
    check("arst_done", bus.done_vst, 0);
    exp_q.delete();
    done_exp = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle", state_dbg, 0);
    start_store(ramp_vec(16'h8000), 16'h0800, 16'h0001, 16'hFFFF);

    // Randomized stores with random back-pressure
    wait_idle();
    rdy_rand = 1;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0: m = '1;
        1: m = '0;
        default: m = LN'($urandom);
      endcase
      start_store(rand_vec(), AW'($urandom), AW'($urandom), m);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        pulse_ignored_start();
      end
    end
    wait_idle();
    rdy_rand = 0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_exp, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
